// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, runs a request/done
//               handshake with a variable-latency instruction memory, keeps a
//               one-entry skid buffer for words that arrive while decode is
//               stalled, tracks redirects that land while a request is in
//               flight, and parks on a fetched HALT until redirected.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] PC_Next,
  output logic        instr_valid,
  output logic        halted
);

  // REQ: request outstanding or about to issue; HOLD: word parked in the skid
  // buffer waiting for decode; HALTED: a HALT was delivered, no fetching.
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [15:0] C_PC_STEP = 16'd2;

  // Architectural state
  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_pend_redir;
  logic [15:0] r_tgt;
  logic        r_buf_valid;
  logic [15:0] r_buf_instr;
  logic [15:0] r_buf_pcn;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pcn;
  logic        r_ifid_valid;

  // Next-state values
  state_t      w_state;
  logic [15:0] w_pc;
  logic        w_pend_redir;
  logic [15:0] w_tgt;
  logic        w_buf_valid;
  logic [15:0] w_buf_instr;
  logic [15:0] w_buf_pcn;
  logic [15:0] w_ifid_instr;
  logic [15:0] w_ifid_pcn;
  logic        w_ifid_valid;

  logic [15:0] w_pc_inc;
  logic        w_rdata_is_halt;
  logic        w_buf_is_halt;

  assign w_pc_inc        = r_pc + C_PC_STEP;
  assign w_rdata_is_halt = (imem_rdata[15:11] == HALT_OPC);
  assign w_buf_is_halt   = (r_buf_instr[15:11] == HALT_OPC);

  // Request is suppressed while reset is held so nothing is issued before
  // the first cycle after release.
  assign imem_req    = rst && (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr       = r_ifid_instr;
  assign PC_Next     = r_ifid_pcn;
  assign instr_valid = r_ifid_valid;
  assign halted      = (r_state == S_HALTED);

  // Next-state, PC, skid buffer and IF/ID update logic.
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_pend_redir = r_pend_redir;
    w_tgt        = r_tgt;
    w_buf_valid  = r_buf_valid;
    w_buf_instr  = r_buf_instr;
    w_buf_pcn    = r_buf_pcn;
    w_ifid_instr = r_ifid_instr;
    w_ifid_pcn   = r_ifid_pcn;
    w_ifid_valid = r_ifid_valid;

    case (r_state)
      S_REQ: begin
        if (imem_done) begin
          if (redirect) begin
            // Fresh redirect wins over both the returning word and any
            // target remembered from earlier in this request.
            w_pc         = redirect_pc;
            w_pend_redir = 1'b0;
            w_ifid_instr = NOP_INSTR;
            w_ifid_valid = 1'b0;
          end else if (r_pend_redir) begin
            // Word belongs to the squashed path; discard it and refetch.
            w_pc         = r_tgt;
            w_pend_redir = 1'b0;
            if (!stall) begin
              w_ifid_instr = NOP_INSTR;
              w_ifid_valid = 1'b0;
            end
          end else if (!stall) begin
            w_ifid_instr = imem_rdata;
            w_ifid_pcn   = w_pc_inc;
            w_ifid_valid = 1'b1;
            w_pc         = w_pc_inc;
            w_state      = w_rdata_is_halt ? S_HALTED : S_REQ;
          end else begin
            // Decode is busy: park the word and stop requesting.
            w_buf_valid  = 1'b1;
            w_buf_instr  = imem_rdata;
            w_buf_pcn    = w_pc_inc;
            w_pc         = w_pc_inc;
            w_state      = S_HOLD;
          end
        end else begin
          if (redirect) begin
            // The address cannot move mid-request; remember the target and
            // apply it when the outstanding response comes back.
            w_pend_redir = 1'b1;
            w_tgt        = redirect_pc;
            w_ifid_instr = NOP_INSTR;
            w_ifid_valid = 1'b0;
          end else if (!stall) begin
            w_ifid_instr = NOP_INSTR;
            w_ifid_valid = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          w_pc         = redirect_pc;
          w_buf_valid  = 1'b0;
          w_ifid_instr = NOP_INSTR;
          w_ifid_valid = 1'b0;
          w_state      = S_REQ;
        end else if (!stall) begin
          w_ifid_instr = r_buf_instr;
          w_ifid_pcn   = r_buf_pcn;
          w_ifid_valid = r_buf_valid;
          w_buf_valid  = 1'b0;
          w_state      = w_buf_is_halt ? S_HALTED : S_REQ;
        end
      end

      S_HALTED: begin
        if (redirect) begin
          // A HALT fetched down a mispredicted path must not stick.
          w_pc         = redirect_pc;
          w_buf_valid  = 1'b0;
          w_ifid_instr = NOP_INSTR;
          w_ifid_valid = 1'b0;
          w_state      = S_REQ;
        end else if (!stall) begin
          w_ifid_instr = NOP_INSTR;
          w_ifid_valid = 1'b0;
        end
      end

      default: begin
        w_state = S_REQ;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_pend_redir <= 1'b0;
      r_tgt        <= RESET_PC;
      r_buf_valid  <= 1'b0;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pcn    <= RESET_PC + C_PC_STEP;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pcn   <= RESET_PC + C_PC_STEP;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_pend_redir <= w_pend_redir;
      r_tgt        <= w_tgt;
      r_buf_valid  <= w_buf_valid;
      r_buf_instr  <= w_buf_instr;
      r_buf_pcn    <= w_buf_pcn;
      r_ifid_instr <= w_ifid_instr;
      r_ifid_pcn   <= w_ifid_pcn;
      r_ifid_valid <= w_ifid_valid;
    end
  end

endmodule
`default_nettype wire
